// File: rtl/mem_if_pkg.sv
// mem_if_pkg: command, response and in-flight metadata types for the data-memory initiator.
package mem_if_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int ID_WIDTH = 4;
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_WIDTH = 64;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ID_WIDTH-1:0]   id;
  } mem_cmd_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  we;
    logic [ID_WIDTH-1:0]   id;
  } mem_resp_t;
  typedef struct packed {
    logic                we;
    logic [ID_WIDTH-1:0] id;
  } mem_meta_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-2 depth FIFO with registered storage and extra-MSB full/empty pointers.
module sync_fifo #(
  parameter int  DEPTH   = 4,
  parameter type dtype_t = logic
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  dtype_t data_i,
  input  logic   pop_i,
  output dtype_t data_o,
  output logic   empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr_q, rptr_q;
  logic        full;
  dtype_t      mem_q [DEPTH];
  assign empty_o = wptr_q == rptr_q;
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign data_o  = mem_q[rptr_q[AW-1:0]];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '{default: '0};
    end else begin
      if (push_i) begin
        mem_q[wptr_q[AW-1:0]] <= data_i;
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop_i) rptr_q <= rptr_q + 1'b1;
    end
  end
  no_overflow:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full));
  no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o));
endmodule

// File: rtl/mem_req_initiator.sv
// mem_req_initiator: credit-limited initiator issuing load/store commands to a single-cycle data memory
// and returning its responses in order.
module mem_req_initiator
  import mem_if_pkg::*;
#(
  parameter int DATA_WIDTH      = mem_if_pkg::DATA_WIDTH,
  parameter int ID_WIDTH        = mem_if_pkg::ID_WIDTH,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [63:0]             cmd_addr_i,
  input  logic                    cmd_we_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [ID_WIDTH-1:0]     cmd_id_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    resp_we_o,
  output logic [ID_WIDTH-1:0]     resp_id_o,
  output logic [63:0]             data_if_address_o,
  output logic                    data_if_data_req_o,
  output logic [DATA_WIDTH/8-1:0] data_if_data_be_o,
  output logic [DATA_WIDTH-1:0]   data_if_data_wdata_o,
  output logic                    data_if_data_we_o,
  input  logic                    data_if_data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   data_if_data_rdata_i,
  output logic                    err_o
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, err_q;
  mem_cmd_t      cmd_q;
  mem_meta_t     meta;
  mem_resp_t     resp;
  logic          cmd_hs, resp_hs, meta_empty, resp_empty, rsp_push, stray;
  assign cmd_ready_o = cnt_q < MAX_CNT;
  assign cmd_hs      = cmd_valid_i && cmd_ready_o;
  assign resp_hs     = resp_valid_o && resp_ready_i;
  assign cnt_d       = cnt_q + CW'(cmd_hs) - CW'(resp_hs);
  // A response without a recorded access has no owner; it is dropped and flagged.
  assign rsp_push    = data_if_data_rvalid_i && !meta_empty;
  assign stray       = data_if_data_rvalid_i && meta_empty;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      req_q <= 1'b0;
      cmd_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      req_q <= cmd_hs;
      if (cmd_hs) cmd_q <= '{addr: cmd_addr_i, we: cmd_we_i, be: cmd_be_i, wdata: cmd_wdata_i, id: cmd_id_i};
      if (stray) err_q <= 1'b1;
    end
  end
  assign data_if_address_o    = cmd_q.addr;
  assign data_if_data_req_o   = req_q;
  assign data_if_data_be_o    = cmd_q.be;
  assign data_if_data_wdata_o = cmd_q.wdata;
  assign data_if_data_we_o    = req_q && cmd_q.we;
  assign err_o                = err_q;
  sync_fifo #(.DEPTH(MAX_OUTSTANDING), .dtype_t(mem_meta_t)) u_meta_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (req_q),
    .data_i  ('{we: cmd_q.we, id: cmd_q.id}),
    .pop_i   (rsp_push),
    .data_o  (meta),
    .empty_o (meta_empty)
  );
  sync_fifo #(.DEPTH(MAX_OUTSTANDING), .dtype_t(mem_resp_t)) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rsp_push),
    .data_i  ('{rdata: data_if_data_rdata_i, we: meta.we, id: meta.id}),
    .pop_i   (resp_hs),
    .data_o  (resp),
    .empty_o (resp_empty)
  );
  assign resp_valid_o = !resp_empty;
  assign resp_rdata_o = resp.rdata;
  assign resp_we_o    = resp.we;
  assign resp_id_o    = resp.id;
endmodule

// File: tb/tb_mem_req_initiator.sv
// tb_mem_req_initiator: directed and random traffic against a behavioural memory, checked by an in-order scoreboard.
module tb_mem_req_initiator;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0, cmd_ready_o;
  logic [63:0] cmd_addr_i = '0;
  logic        cmd_we_i = 1'b0;
  logic [7:0]  cmd_be_i = '0;
  logic [63:0] cmd_wdata_i = '0;
  logic [3:0]  cmd_id_i = '0;
  logic        resp_valid_o, resp_ready_i = 1'b1, resp_we_o;
  logic [63:0] resp_rdata_o;
  logic [3:0]  resp_id_o;
  logic [63:0] data_if_address_o, data_if_data_wdata_o, data_if_data_rdata_i;
  logic        data_if_data_req_o, data_if_data_we_o, data_if_data_rvalid_i, err_o;
  logic [7:0]  data_if_data_be_o;

  typedef struct {
    logic [63:0] rdata;
    logic        we;
    logic [3:0]  id;
  } exp_t;
  exp_t        exp_q[$];
  logic [63:0] mem [logic [60:0]];
  logic [63:0] ref_mem [logic [60:0]];
  int          vectors = 0, miscompares = 0, accepts = 0, we_pulses = 0;
  logic [7:0]  last_be = '0;
  logic        stray = 1'b0, mem_rvalid;
  logic [63:0] mem_rdata = '0, mem_old;
  logic [60:0] mem_w;

  always #5 clk_i = ~clk_i;

  mem_req_initiator dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_we_i(cmd_we_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i), .cmd_id_i(cmd_id_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_rdata_o(resp_rdata_o),
    .resp_we_o(resp_we_o), .resp_id_o(resp_id_o),
    .data_if_address_o(data_if_address_o), .data_if_data_req_o(data_if_data_req_o),
    .data_if_data_be_o(data_if_data_be_o), .data_if_data_wdata_o(data_if_data_wdata_o),
    .data_if_data_we_o(data_if_data_we_o), .data_if_data_rvalid_i(data_if_data_rvalid_i),
    .data_if_data_rdata_i(data_if_data_rdata_i), .err_o(err_o)
  );

  assign data_if_data_rvalid_i = mem_rvalid | stray;
  assign data_if_data_rdata_i  = mem_rdata;

  function automatic logic [63:0] init_word(logic [60:0] w);
    return {w[31:0] ^ 32'h5A5A_C3C3, ~w[31:0]};
  endfunction

  function automatic logic [63:0] merge(logic [63:0] old, logic [7:0] be, logic [63:0] wd);
    logic [63:0] r = old;
    for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Word-addressed memory: every access returns the word before any write, one cycle after req.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mem_rvalid <= 1'b0;
    else begin
      mem_rvalid <= data_if_data_req_o;
      if (data_if_data_req_o) begin
        mem_w   = data_if_address_o[63:3];
        mem_old = mem.exists(mem_w) ? mem[mem_w] : init_word(mem_w);
        mem_rdata <= mem_old;
        if (data_if_data_we_o) mem[mem_w] = merge(mem_old, data_if_data_be_o, data_if_data_wdata_o);
      end
    end
  end

  // Scoreboard: expectations are formed at command acceptance, consumed at response handshake.
  always @(negedge clk_i) begin
    exp_t        e;
    logic [60:0] w;
    logic [63:0] old;
    if (rst_ni) begin
      if (data_if_data_we_o) begin
        we_pulses++;
        last_be = data_if_data_be_o;
      end
      if (!data_if_data_req_o) check("we_while_idle", {63'd0, data_if_data_we_o}, 64'd0);
      if (resp_valid_o && resp_ready_i) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_resp: got id %0d with nothing expected", resp_id_o);
        end else begin
          e = exp_q.pop_front();
          check("resp_rdata", resp_rdata_o, e.rdata);
          check("resp_we", {63'd0, resp_we_o}, {63'd0, e.we});
          check("resp_id", {60'd0, resp_id_o}, {60'd0, e.id});
        end
      end
      if (cmd_valid_i && cmd_ready_o) begin
        accepts++;
        w   = cmd_addr_i[63:3];
        old = ref_mem.exists(w) ? ref_mem[w] : init_word(w);
        e.rdata = old;
        e.we    = cmd_we_i;
        e.id    = cmd_id_i;
        exp_q.push_back(e);
        if (cmd_we_i) ref_mem[w] = merge(old, cmd_be_i, cmd_wdata_i);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cmd(logic v, logic [63:0] a, logic we, logic [7:0] be, logic [63:0] wd, logic [3:0] id);
    cmd_valid_i = v;
    cmd_addr_i  = a;
    cmd_we_i    = we;
    cmd_be_i    = be;
    cmd_wdata_i = wd;
    cmd_id_i    = id;
  endtask

  task automatic drain();
    int n = 0;
    cmd_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, p;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_cmd_ready", {63'd0, cmd_ready_o}, 64'd1);
    check("rst_resp_valid", {63'd0, resp_valid_o}, 64'd0);
    check("rst_req", {63'd0, data_if_data_req_o}, 64'd0);
    check("rst_we", {63'd0, data_if_data_we_o}, 64'd0);
    check("rst_err", {63'd0, err_o}, 64'd0);
    check("rst_addr", data_if_address_o, 64'd0);
    check("rst_rdata", resp_rdata_o, 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    mem[61'h1000_0000]     = 64'hDEAD_BEEF_0123_4567;
    ref_mem[61'h1000_0000] = 64'hDEAD_BEEF_0123_4567;
    set_cmd(1'b1, 64'h8000_0000, 1'b0, 8'hFF, 64'd0, 4'd3);
    @(negedge clk_i);
    check("load_req_n", {63'd0, data_if_data_req_o}, 64'd0);
    tick();
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    check("load_req_n1", {63'd0, data_if_data_req_o}, 64'd1);
    check("load_addr", data_if_address_o, 64'h8000_0000);
    tick();
    @(negedge clk_i);
    check("load_req_n2", {63'd0, data_if_data_req_o}, 64'd0);
    check("load_valid_n2", {63'd0, resp_valid_o}, 64'd0);
    tick();
    @(negedge clk_i);
    check("load_valid_n3", {63'd0, resp_valid_o}, 64'd1);
    check("load_rdata_n3", resp_rdata_o, 64'hDEAD_BEEF_0123_4567);
    tick();

    p = we_pulses;
    set_cmd(1'b1, 64'h8000_0008, 1'b1, 8'h0F, 64'h1122_3344_5566_7788, 4'd5);
    tick();
    set_cmd(1'b1, 64'h8000_0008, 1'b0, 8'hFF, 64'd0, 4'd6);
    tick();
    cmd_valid_i = 1'b0;
    repeat (4) tick();
    @(negedge clk_i);
    check("store_we_pulses", 64'(we_pulses - p), 64'd1);
    check("store_be", {56'd0, last_be}, 64'h0F);
    tick();

    resp_ready_i = 1'b0;
    a0 = accepts;
    for (int i = 0; i < 6; i++) begin
      set_cmd(1'b1, 64'h8000_0040 + 64'(8 * i), 1'b0, 8'hFF, 64'd0, 4'(i));
      @(negedge clk_i);
      check("bp_ready", {63'd0, cmd_ready_o}, (i < 4) ? 64'd1 : 64'd0);
      tick();
    end
    @(negedge clk_i);
    check("bp_accepts", 64'(accepts - a0), 64'd4);
    check("bp_ready_full", {63'd0, cmd_ready_o}, 64'd0);
    tick();

    set_cmd(1'b1, 64'h8000_0060, 1'b0, 8'hFF, 64'd0, 4'd4);
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    check("pop_same_cycle_ready", {63'd0, cmd_ready_o}, 64'd0);
    tick();
    @(negedge clk_i);
    check("after_pop_ready", {63'd0, cmd_ready_o}, 64'd1);
    tick();
    resp_ready_i = 1'b0;
    set_cmd(1'b1, 64'h8000_0068, 1'b0, 8'hFF, 64'd0, 4'd5);
    @(negedge clk_i);
    check("cnt_held_ready", {63'd0, cmd_ready_o}, 64'd1);
    tick();
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    check("cnt_full_again", {63'd0, cmd_ready_o}, 64'd0);
    drain();

    repeat (400) begin
      set_cmd(1'($urandom_range(0, 1)), 64'h8000_0000 + 64'(8 * $urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 8'($urandom), {$urandom, $urandom}, 4'($urandom));
      resp_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    repeat (3) tick();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    @(negedge clk_i);
    check("stray_err", {63'd0, err_o}, 64'd1);
    check("stray_no_resp", {63'd0, resp_valid_o}, 64'd0);
    repeat (5) tick();
    @(negedge clk_i);
    check("stray_err_sticky", {63'd0, err_o}, 64'd1);
    check("stray_no_resp_late", {63'd0, resp_valid_o}, 64'd0);
    tick();

    resp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(1'b1, 64'h8000_0100 + 64'(8 * i), 1'b0, 8'hFF, 64'd0, 4'(8 + i));
      tick();
    end
    cmd_valid_i = 1'b0;
    repeat (4) tick();
    @(negedge clk_i);
    check("queued_valid", {63'd0, resp_valid_o}, 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, resp_valid_o}, 64'd0);
    check("async_rst_ready", {63'd0, cmd_ready_o}, 64'd1);
    check("async_rst_err", {63'd0, err_o}, 64'd0);
    exp_q.delete();
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    set_cmd(1'b1, 64'h8000_0000, 1'b0, 8'hFF, 64'd0, 4'd7);
    tick();
    drain();
    repeat (2) tick();
    @(negedge clk_i);
    check("final_idle_valid", {63'd0, resp_valid_o}, 64'd0);
    check("final_err", {63'd0, err_o}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
